rd_fram_reader: RTL and testbench

- Read-side consumer of the frame read buffer: 4096×32 read port, filled with 256-bit words by the DDR read path.
- Sits in the video pixel domain, between the timing generator (vs/hs/de) and the HDMI/LCD output.
- Drives the buffer read address and treats the buffer as two ping-pong halves.
- Requests a refill of each half once it has been drained, and outputs pixel data aligned with delayed sync signals.

---
 rtl/rd_fram_reader_if.sv | 23 ++
 rtl/rd_fram_reader.sv | 182 ++++++++++++++++++
 tb/tb_rd_fram_reader.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rd_fram_reader_if.sv
// rtl/rd_fram_reader_if.sv - refill handshake, fill notification and buffer read port bundle
interface rd_fram_reader_if #(
    parameter int RD_ADDR_WIDTH = 12,
    parameter int RD_DATA_WIDTH = 32
);
    logic                     fram_req;
    logic                     fram_req_half;
    logic                     fram_req_ready;
    logic                     fram_fill_done;
    logic                     fram_fill_half;
    logic [RD_ADDR_WIDTH-1:0] rd_addr;
    logic [RD_DATA_WIDTH-1:0] rd_data;

    modport master (
        output fram_req, fram_req_half, rd_addr,
        input  fram_req_ready, fram_fill_done, fram_fill_half, rd_data
    );

    modport slave (
        input  fram_req, fram_req_half, rd_addr,
        output fram_req_ready, fram_fill_done, fram_fill_half, rd_data
    );
endinterface

// File: rtl/rd_fram_reader.sv
// rtl/rd_fram_reader.sv - ping-pong frame buffer reader feeding the pixel output path
module rd_fram_reader #(
    parameter int RD_ADDR_WIDTH = 12,
    parameter int RD_DATA_WIDTH = 32,
    parameter int FRAME_WORDS   = 2073600,
    parameter bit VS_POL        = 1'b1
) (
    input  logic                     rd_clk,
    input  logic                     rd_rst,
    input  logic                     vs_in,
    input  logic                     hs_in,
    input  logic                     de_in,
    rd_fram_reader_if.master         fram,
    output logic                     vs_out,
    output logic                     hs_out,
    output logic                     de_out,
    output logic [RD_DATA_WIDTH-1:0] pix_data,
    output logic                     underrun,
    output logic                     frame_busy
);
    localparam int          LOW_W     = RD_ADDR_WIDTH - 1;
    localparam int          HALF_WORDS = 2 ** LOW_W;
    localparam logic [31:0] HALF_INC  = 32'(HALF_WORDS);
    localparam logic [31:0] FRAME_LIM = 32'(FRAME_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [RD_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0]               half_full_q, half_full_d;
    logic [1:0]               req_pend_q, req_pend_d;
    logic                     fram_req_q, fram_req_d;
    logic                     fram_req_half_q, fram_req_half_d;
    logic                     next_half_q, next_half_d;
    logic [31:0]              req_words_q, req_words_d;
    logic                     underrun_q, underrun_d;
    logic [1:0]               vs_tap_q, vs_tap_d;
    logic [1:0]               hs_tap_q, hs_tap_d;
    logic                     de_tap_q, de_tap_d;
    logic                     de_out_q, de_out_d;
    logic [RD_DATA_WIDTH-1:0] pix_data_q, pix_data_d;

    logic frame_start;
    logic accept;
    logic rd_en;
    logic drain;
    logic cur_half;

    // vs_tap_q[0] doubles as the registered copy used for frame-start edge detection
    assign frame_start = (vs_in == VS_POL) && (vs_tap_q[0] != VS_POL);
    assign accept      = fram_req_q && fram.fram_req_ready;
    assign rd_en       = (state_q == ST_RUN) && de_in;
    assign cur_half    = rd_ptr_q[RD_ADDR_WIDTH-1];
    assign drain       = rd_en && (&rd_ptr_q[LOW_W-1:0]);

    assign fram.fram_req      = fram_req_q;
    assign fram.fram_req_half = fram_req_half_q;
    assign fram.rd_addr       = rd_ptr_q;
    assign vs_out             = vs_tap_q[1];
    assign hs_out             = hs_tap_q[1];
    assign de_out             = de_out_q;
    assign pix_data           = pix_data_q;
    assign underrun           = underrun_q;
    assign frame_busy         = (state_q != ST_IDLE);

    // Frame sequencing: any frame start (re)enters PREFILL, both halves full releases RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (frame_start) state_d = ST_PREFILL;
            ST_PREFILL: begin
                if (frame_start)              state_d = ST_PREFILL;
                else if (half_full_q == 2'b11) state_d = ST_RUN;
            end
            ST_RUN:     if (frame_start) state_d = ST_PREFILL;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Pointer, fill flags, refill requests and underrun tracking
    always_comb begin
        rd_ptr_d        = rd_ptr_q;
        half_full_d     = half_full_q;
        req_pend_d      = req_pend_q;
        fram_req_d      = fram_req_q;
        fram_req_half_d = fram_req_half_q;
        next_half_d     = next_half_q;
        req_words_d     = req_words_q;
        underrun_d      = underrun_q;

        if (frame_start) begin
            // Restart the frame: an in-flight request and a coincident fill are abandoned
            rd_ptr_d        = '0;
            half_full_d     = 2'b00;
            req_pend_d      = 2'b11;
            req_words_d     = '0;
            underrun_d      = 1'b0;
            fram_req_d      = 1'b0;
            fram_req_half_d = 1'b0;
            next_half_d     = 1'b0;
        end else begin
            if (accept) begin
                req_pend_d[fram_req_half_q] = 1'b0;
                req_words_d                 = req_words_q + HALF_INC;
                fram_req_d                  = 1'b0;
                next_half_d                 = ~fram_req_half_q;
            end else if (!fram_req_q) begin
                if (req_words_q >= FRAME_LIM) begin
                    // Whole frame already requested: drained halves need no refill
                    req_pend_d = 2'b00;
                end else if (req_pend_q[next_half_q]) begin
                    fram_req_d      = 1'b1;
                    fram_req_half_d = next_half_q;
                end
            end

            if (fram.fram_fill_done) begin
                half_full_d[fram.fram_fill_half] = 1'b1;
            end

            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + {{(RD_ADDR_WIDTH-1){1'b0}}, 1'b1};
                if (!half_full_q[cur_half]) begin
                    underrun_d = 1'b1;
                end
                // Last word of a half consumed; placed after the fill so the clear wins
                if (drain) begin
                    half_full_d[cur_half] = 1'b0;
                    req_pend_d[cur_half]  = 1'b1;
                end
            end
        end
    end

    // Two-stage output alignment; de/pixel gated by the state being entered
    always_comb begin
        vs_tap_d   = {vs_tap_q[0], vs_in};
        hs_tap_d   = {hs_tap_q[0], hs_in};
        de_tap_d   = rd_en;
        de_out_d   = de_tap_q && (state_d == ST_RUN);
        pix_data_d = de_out_d ? fram.rd_data : '0;
    end

    // State register with synchronous active-high reset
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_q         <= ST_IDLE;
            rd_ptr_q        <= '0;
            half_full_q     <= 2'b00;
            req_pend_q      <= 2'b00;
            fram_req_q      <= 1'b0;
            fram_req_half_q <= 1'b0;
            next_half_q     <= 1'b0;
            req_words_q     <= '0;
            underrun_q      <= 1'b0;
            vs_tap_q        <= 2'b00;
            hs_tap_q        <= 2'b00;
            de_tap_q        <= 1'b0;
            de_out_q        <= 1'b0;
            pix_data_q      <= '0;
        end else begin
            state_q         <= state_d;
            rd_ptr_q        <= rd_ptr_d;
            half_full_q     <= half_full_d;
            req_pend_q      <= req_pend_d;
            fram_req_q      <= fram_req_d;
            fram_req_half_q <= fram_req_half_d;
            next_half_q     <= next_half_d;
            req_words_q     <= req_words_d;
            underrun_q      <= underrun_d;
            vs_tap_q        <= vs_tap_d;
            hs_tap_q        <= hs_tap_d;
            de_tap_q        <= de_tap_d;
            de_out_q        <= de_out_d;
            pix_data_q      <= pix_data_d;
        end
    end
endmodule

// File: tb/tb_rd_fram_reader.sv
// tb/tb_rd_fram_reader.sv - self-checking bench for rd_fram_reader
module tb_rd_fram_reader;
    localparam int AW   = 12;
    localparam int DW   = 32;
    localparam int FW   = 6144;
    localparam int HALF = 2048;
    localparam int SIZE = 4096;

    logic          rd_clk = 1'b0;
    logic          rd_rst = 1'b1;
    logic          vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0;
    logic          vs_out, hs_out, de_out, underrun, frame_busy;
    logic [DW-1:0] pix_data;
    logic [DW-1:0] salt;

    rd_fram_reader_if #(.RD_ADDR_WIDTH(AW), .RD_DATA_WIDTH(DW)) fif ();

    rd_fram_reader #(
        .RD_ADDR_WIDTH(AW), .RD_DATA_WIDTH(DW), .FRAME_WORDS(FW), .VS_POL(1'b1)
    ) dut (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
        .fram(fif), .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out),
        .pix_data(pix_data), .underrun(underrun), .frame_busy(frame_busy)
    );

    always #5 rd_clk = ~rd_clk;

    // Buffer RAM: content is the address scrambled by a per-run salt, one cycle latency
    always @(posedge rd_clk) fif.rd_data <= {{(DW-AW){1'b0}}, fif.rd_addr} ^ salt;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic          v;
        logic          h;
        logic          d;
        logic [AW-1:0] a;
    } rec_t;

    // Reference model state
    int            m_st;      // 0 idle, 1 prefill, 2 run
    logic [1:0]    m_full;
    int            m_ptr;
    int            m_reads;
    logic          m_und;
    logic          m_vsprev;
    rec_t          h1, h2;
    logic          e_vs, e_hs, e_de;
    logic [DW-1:0] e_pix;
    int            acc_q[$];
    int            req_hi_cycles;
    int            b2b;
    logic          prev_acc;

    task automatic tick();
        rec_t       cur;
        logic       fs, run_b, acc;
        logic [1:0] full_b;
        acc = !rd_rst && (fif.fram_req === 1'b1) && (fif.fram_req_ready === 1'b1);
        if (!rd_rst && fif.fram_req === 1'b1) begin
            req_hi_cycles++;
            if (prev_acc) b2b++;
        end
        if (acc) acc_q.push_back(int'(fif.fram_req_half));
        prev_acc = acc;
        @(posedge rd_clk);
        #1;
        if (rd_rst) begin
            m_st = 0; m_full = 2'b00; m_ptr = 0; m_reads = 0;
            m_und = 1'b0; m_vsprev = 1'b0; h1 = '0; h2 = '0; prev_acc = 1'b0;
        end else begin
            fs       = (vs_in === 1'b1) && !m_vsprev;
            m_vsprev = vs_in;
            run_b    = (m_st == 2);
            full_b   = m_full;
            cur.v = vs_in; cur.h = hs_in; cur.d = de_in && run_b; cur.a = AW'(m_ptr);
            if (fs) begin
                m_st = 1; m_ptr = 0; m_reads = 0; m_full = 2'b00; m_und = 1'b0;
            end else begin
                if (fif.fram_fill_done) m_full[fif.fram_fill_half] = 1'b1;
                if (run_b && de_in) begin
                    if (!full_b[m_ptr / HALF]) m_und = 1'b1;
                    if (m_ptr % HALF == HALF - 1) m_full[m_ptr / HALF] = 1'b0;
                    m_ptr = (m_ptr + 1) % SIZE;
                    m_reads++;
                end
                if (m_st == 1 && full_b == 2'b11) m_st = 2;
            end
            h2 = h1;
            h1 = cur;
        end
        e_vs  = h2.v;
        e_hs  = h2.h;
        e_de  = h2.d && (m_st == 2);
        e_pix = e_de ? ({{(DW-AW){1'b0}}, h2.a} ^ salt) : '0;
    endtask

    task automatic pulse_fill(input logic half);
        fif.fram_fill_done = 1'b1;
        fif.fram_fill_half = half;
        tick();
        fif.fram_fill_done = 1'b0;
    endtask

    task automatic test_reset();
        rd_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vs_in = 1'($urandom_range(0, 1));
            hs_in = 1'($urandom_range(0, 1));
            de_in = 1'($urandom_range(0, 1));
            tick();
            n_cmp++;
            if ({vs_out, hs_out, de_out, underrun, frame_busy, fif.fram_req} !== 6'b0 ||
                pix_data !== '0 || fif.rd_addr !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs cyc=%0d vs/hs/de/und/busy/req=%b%b%b%b%b%b pix=%h addr=%0d want all 0",
                         i, vs_out, hs_out, de_out, underrun, frame_busy, fif.fram_req, pix_data, fif.rd_addr);
            end
        end
        rd_rst = 1'b0; vs_in = 1'b0; hs_in = 1'b0; de_in = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (frame_busy !== 1'b0 || fif.fram_req !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset busy=%b req=%b want 0 0", frame_busy, fif.fram_req);
        end
    endtask

    task automatic test_prefill();
        fif.fram_req_ready = 1'b1;
        acc_q.delete(); b2b = 0; req_hi_cycles = 0;
        vs_in = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        n_cmp++;
        if (acc_q.size() != 2 || acc_q[0] != 0 || acc_q[1] != 1) begin
            n_bad++;
            $display("FAIL prefill_req_order got %0d reqs (%p) want halves 0,1", acc_q.size(), acc_q);
        end
        n_cmp++;
        if (b2b != 0 || req_hi_cycles != 2) begin
            n_bad++;
            $display("FAIL prefill_req_pulse b2b=%0d high_cycles=%0d want 0 and 2", b2b, req_hi_cycles);
        end
        n_cmp++;
        if (frame_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL prefill_busy got %b want 1", frame_busy);
        end
        pulse_fill(1'b0);
        repeat (3) tick();
        pulse_fill(1'b1);
        de_in = 1'b1;
        tick();
        n_cmp++;
        if (fif.rd_addr !== 12'd0 || de_out !== 1'b0) begin
            n_bad++;
            $display("FAIL run_entry_first addr=%0d de_out=%b want 0 0", fif.rd_addr, de_out);
        end
        tick();
        n_cmp++;
        if (fif.rd_addr !== 12'd1) begin
            n_bad++;
            $display("FAIL run_entry_second addr=%0d want 1", fif.rd_addr);
        end
    endtask

    task automatic test_stream();
        int budget;
        fif.fram_req_ready = 1'b1;
        budget = 0;
        while (m_reads < HALF && budget < 6000) begin
            de_in = ($urandom_range(0, 7) != 0);
            hs_in = 1'($urandom_range(0, 1));
            tick();
            budget++;
            n_cmp++;
            if (de_out !== e_de || pix_data !== e_pix || vs_out !== e_vs || hs_out !== e_hs ||
                fif.rd_addr !== AW'(m_ptr) || underrun !== m_und) begin
                n_bad++;
                $display("FAIL stream_a t=%0t de/pix/vs/hs/addr/und=%b %h %b %b %0d %b want %b %h %b %b %0d %b",
                         $time, de_out, pix_data, vs_out, hs_out, fif.rd_addr, underrun,
                         e_de, e_pix, e_vs, e_hs, m_ptr, m_und);
            end
        end
        de_in = 1'b0;
        budget = 0;
        while (acc_q.size() < 3 && budget < 10) begin
            tick();
            budget++;
        end
        n_cmp++;
        if (acc_q.size() != 3 || acc_q[2] != 0) begin
            n_bad++;
            $display("FAIL refill_half0 got %0d reqs (%p) want third request for half 0", acc_q.size(), acc_q);
        end
        pulse_fill(1'b0);
        budget = 0;
        while (m_reads < 2 * HALF + 4 && budget < 8000) begin
            de_in = ($urandom_range(0, 7) != 0);
            hs_in = 1'($urandom_range(0, 1));
            tick();
            budget++;
            n_cmp++;
            if (de_out !== e_de || pix_data !== e_pix || vs_out !== e_vs || hs_out !== e_hs ||
                fif.rd_addr !== AW'(m_ptr) || underrun !== m_und) begin
                n_bad++;
                $display("FAIL stream_b t=%0t de/pix/vs/hs/addr/und=%b %h %b %b %0d %b want %b %h %b %b %0d %b",
                         $time, de_out, pix_data, vs_out, hs_out, fif.rd_addr, underrun,
                         e_de, e_pix, e_vs, e_hs, m_ptr, m_und);
            end
        end
        de_in = 1'b0;
        n_cmp++;
        if (m_reads < 2 * HALF + 4) begin
            n_bad++;
            $display("FAIL stream_timeout reads=%0d want %0d", m_reads, 2 * HALF + 4);
        end
        repeat (20) tick();
        n_cmp++;
        if (underrun !== 1'b0 || acc_q.size() != 3 || fif.fram_req !== 1'b0) begin
            n_bad++;
            $display("FAIL frame_end und=%b reqs=%0d req=%b want 0 3 0", underrun, acc_q.size(), fif.fram_req);
        end
    endtask

    task automatic test_underrun();
        int budget;
        vs_in = 1'b0; de_in = 1'b0;
        tick();
        vs_in = 1'b1;
        tick();
        pulse_fill(1'b0);
        pulse_fill(1'b1);
        budget = 0;
        while (m_st != 2 && budget < 10) begin
            tick();
            budget++;
        end
        de_in = 1'b1;
        budget = 0;
        while (m_reads < 2 * HALF + 3 && budget < 5000) begin
            hs_in = 1'($urandom_range(0, 1));
            tick();
            budget++;
            n_cmp++;
            if (de_out !== e_de || pix_data !== e_pix || fif.rd_addr !== AW'(m_ptr) || underrun !== m_und) begin
                n_bad++;
                $display("FAIL underrun_stream t=%0t de/pix/addr/und=%b %h %0d %b want %b %h %0d %b",
                         $time, de_out, pix_data, fif.rd_addr, underrun, e_de, e_pix, m_ptr, m_und);
            end
        end
        n_cmp++;
        if (underrun !== 1'b1 || fif.rd_addr !== 12'd3) begin
            n_bad++;
            $display("FAIL underrun_set und=%b addr=%0d want 1 3", underrun, fif.rd_addr);
        end
        vs_in = 1'b0;
        tick();
        vs_in = 1'b1;
        fif.fram_fill_done = 1'b1;
        fif.fram_fill_half = 1'b0;
        tick();
        fif.fram_fill_done = 1'b0;
        n_cmp++;
        if (underrun !== 1'b0 || fif.rd_addr !== 12'd0 || frame_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL underrun_clear und=%b addr=%0d busy=%b want 0 0 1", underrun, fif.rd_addr, frame_busy);
        end
        pulse_fill(1'b1);
        repeat (5) tick();
        n_cmp++;
        if (fif.rd_addr !== 12'd0 || de_out !== 1'b0) begin
            n_bad++;
            $display("FAIL entry_fill_ignored addr=%0d de_out=%b want 0 0", fif.rd_addr, de_out);
        end
    endtask

    task automatic test_abort();
        int budget;
        fif.fram_req_ready = 1'b0;
        de_in = 1'b0; vs_in = 1'b0;
        tick();
        acc_q.delete();
        vs_in = 1'b1;
        tick();
        repeat (3) tick();
        n_cmp++;
        if (fif.fram_req !== 1'b1 || fif.fram_req_half !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_req_up req=%b half=%b want 1 0", fif.fram_req, fif.fram_req_half);
        end
        pulse_fill(1'b0);
        pulse_fill(1'b1);
        tick();
        vs_in = 1'b0; de_in = 1'b1;
        budget = 0;
        while (m_ptr < 1000 && budget < 1100) begin
            tick();
            budget++;
            n_cmp++;
            if (fif.fram_req !== 1'b1 || fif.fram_req_half !== 1'b0 || de_out !== e_de ||
                pix_data !== e_pix || fif.rd_addr !== AW'(m_ptr)) begin
                n_bad++;
                $display("FAIL abort_run t=%0t req/half/de/pix/addr=%b %b %b %h %0d want 1 0 %b %h %0d",
                         $time, fif.fram_req, fif.fram_req_half, de_out, pix_data, fif.rd_addr,
                         e_de, e_pix, m_ptr);
            end
        end
        vs_in = 1'b1;
        tick();
        n_cmp++;
        if (fif.rd_addr !== 12'd0 || frame_busy !== 1'b1 || de_out !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_restart addr=%0d busy=%b de_out=%b want 0 1 0", fif.rd_addr, frame_busy, de_out);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (de_out !== 1'b0 || pix_data !== '0 || fif.rd_addr !== 12'd0) begin
                n_bad++;
                $display("FAIL abort_prefill_quiet cyc=%0d de_out=%b pix=%h addr=%0d want 0 0 0",
                         i, de_out, pix_data, fif.rd_addr);
            end
        end
        fif.fram_req_ready = 1'b1;
        budget = 0;
        while (acc_q.size() < 2 && budget < 20) begin
            tick();
            budget++;
        end
        n_cmp++;
        if (acc_q.size() != 2 || acc_q[0] != 0 || acc_q[1] != 1) begin
            n_bad++;
            $display("FAIL abort_req_restart got %0d reqs (%p) want halves 0,1", acc_q.size(), acc_q);
        end
        de_in = 1'b0;
    endtask

    task automatic test_reset_mid();
        fif.fram_req_ready = 1'b0;
        vs_in = 1'b0; de_in = 1'b0;
        tick();
        vs_in = 1'b1;
        repeat (4) tick();
        acc_q.delete();
        fif.fram_req_ready = 1'b1;
        rd_rst = 1'b1;
        tick();
        n_cmp++;
        if (fif.fram_req !== 1'b0 || frame_busy !== 1'b0 || acc_q.size() != 0) begin
            n_bad++;
            $display("FAIL reset_mid_handshake req=%b busy=%b accepted=%0d want 0 0 0",
                     fif.fram_req, frame_busy, acc_q.size());
        end
        rd_rst = 1'b0; vs_in = 1'b0;
        repeat (5) tick();
        n_cmp++;
        if (fif.fram_req !== 1'b0 || acc_q.size() != 0) begin
            n_bad++;
            $display("FAIL reset_mid_no_completion req=%b accepted=%0d want 0 0", fif.fram_req, acc_q.size());
        end
    endtask

    initial begin
        salt = $urandom;
        fif.fram_req_ready = 1'b0;
        fif.fram_fill_done = 1'b0;
        fif.fram_fill_half = 1'b0;
        prev_acc = 1'b0; req_hi_cycles = 0; b2b = 0;
        m_st = 0; m_full = 2'b00; m_ptr = 0; m_reads = 0; m_und = 1'b0; m_vsprev = 1'b0;
        h1 = '0; h2 = '0;
        test_reset();
        test_prefill();
        test_stream();
        test_underrun();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
